// File: rtl/mode_counter.sv
// mode_counter: general-purpose timer/sequencer counter.
//
// Counts over 0..MAX_VAL in one of three run modes:
//   00 free-run : wraps at either end, direction taken from `up` every step
//   01 one-shot : stops on the endpoint and raises a sticky `done`
//   10 ping-pong: reflects at either end, direction held internally in cur_up
//   11 reserved : holds, exactly as if en were low
// A synchronous load takes priority over counting and saturates at MAX_VAL.
// Every output is registered. gray is computed from the next count, so it
// changes on the same edge as count with no extra cycle of latency.
//
// Parameters:
//   WIDTH   - count width in bits
//   MAX_VAL - terminal value, 1 <= MAX_VAL <= 2**WIDTH-1
//   WRAP_W  - width of the saturating terminal-event counter
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   en         in   count enable
//   up         in   requested direction (1 = up); used by modes 00/01 and on load
//   load       in   synchronous load strobe, beats en
//   load_value in   value to load, clamped to MAX_VAL
//   mode       in   run mode, see above
//   count      out  binary count
//   gray       out  Gray code of count
//   tc         out  one-cycle pulse after an edge that hit a terminal event
//   done       out  sticky one-shot finished flag, cleared by load or reset
//   cur_up     out  effective direction currently in use
//   wraps      out  saturating count of terminal events

module mode_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = (2 ** WIDTH) - 1,
    parameter int unsigned WRAP_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  count,
    output logic [WIDTH-1:0]  gray,
    output logic              tc,
    output logic              done,
    output logic              cur_up,
    output logic [WRAP_W-1:0] wraps
);

    typedef enum logic [1:0] {
        ModeFree     = 2'b00,
        ModeOneShot  = 2'b01,
        ModePingPong = 2'b10,
        ModeHold     = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0]  MaxV    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0]  One     = WIDTH'(1);
    localparam logic [WRAP_W-1:0] WrapOne = WRAP_W'(1);

    logic [WIDTH-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  gray_q, gray_d;
    logic              tc_q, tc_d;
    logic              done_q, done_d;
    logic              cur_up_q, cur_up_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;

    mode_e             mode_w;
    logic              at_top;
    logic              at_bot;
    logic [WIDTH-1:0]  count_inc;
    logic [WIDTH-1:0]  count_dec;
    logic [WIDTH-1:0]  load_sat;
    logic              term;

    assign mode_w    = mode_e'(mode);
    assign at_top    = (count_q == MaxV);
    assign at_bot    = (count_q == '0);
    assign count_inc = count_q + One;
    assign count_dec = count_q - One;
    assign load_sat  = (load_value > MaxV) ? MaxV : load_value;

    // Next-state for count, direction and done; `term` flags a terminal event.
    always_comb begin
        count_d  = count_q;
        cur_up_d = cur_up_q;
        done_d   = done_q;
        term     = 1'b0;

        if (load) begin
            count_d  = load_sat;
            cur_up_d = up;
            done_d   = 1'b0;
        end else if (en) begin
            unique case (mode_w)
                ModeFree: begin
                    cur_up_d = up;
                    if (up) begin
                        if (at_top) begin
                            count_d = '0;
                            term    = 1'b1;
                        end else begin
                            count_d = count_inc;
                        end
                    end else begin
                        if (at_bot) begin
                            count_d = MaxV;
                            term    = 1'b1;
                        end else begin
                            count_d = count_dec;
                        end
                    end
                end

                ModeOneShot: begin
                    // Once finished the counter is frozen until load/reset.
                    if (!done_q) begin
                        cur_up_d = up;
                        if ((up && at_top) || (!up && at_bot)) begin
                            done_d = 1'b1;
                            term   = 1'b1;
                        end else begin
                            count_d = up ? count_inc : count_dec;
                        end
                    end
                end

                ModePingPong: begin
                    // Reflect at the endpoint: the turnaround edge already
                    // steps one place in the new direction.
                    if (cur_up_q && at_top) begin
                        count_d  = count_dec;
                        cur_up_d = 1'b0;
                        term     = 1'b1;
                    end else if (!cur_up_q && at_bot) begin
                        count_d  = count_inc;
                        cur_up_d = 1'b1;
                        term     = 1'b1;
                    end else begin
                        count_d = cur_up_q ? count_inc : count_dec;
                    end
                end

                ModeHold: begin
                end
            endcase
        end
    end

    // Event outputs and the Gray image of the next count.
    always_comb begin
        tc_d    = term;
        wraps_d = wraps_q;
        if (term && !(&wraps_q)) begin
            wraps_d = wraps_q + WrapOne;
        end
        gray_d = count_d ^ (count_d >> 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            gray_q   <= '0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
            cur_up_q <= 1'b1;
            wraps_q  <= '0;
        end else begin
            count_q  <= count_d;
            gray_q   <= gray_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
            cur_up_q <= cur_up_d;
            wraps_q  <= wraps_d;
        end
    end

    assign count  = count_q;
    assign gray   = gray_q;
    assign tc     = tc_q;
    assign done   = done_q;
    assign cur_up = cur_up_q;
    assign wraps  = wraps_q;

endmodule

// File: tb/tb_mode_counter.sv
// Testbench for mode_counter. Three instances share one stimulus stream:
//   a: MAX_VAL=9, WRAP_W=8   b: MAX_VAL=3, WRAP_W=8   c: MAX_VAL=9, WRAP_W=2
// A behavioural model (integer arithmetic over 0..MAX_VAL) tracks each
// instance; every checked cycle compares all outputs of all three. Directed
// steps also compare against hand-derived constants.

module tb_mode_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_value;
    logic [1:0] mode;

    logic [3:0] cnt_a, gray_a, cnt_b, gray_b, cnt_c, gray_c;
    logic       tc_a, done_a, cu_a, tc_b, done_b, cu_b, tc_c, done_c, cu_c;
    logic [7:0] wr_a, wr_b;
    logic [1:0] wr_c;

    mode_counter #(.WIDTH(4), .MAX_VAL(9), .WRAP_W(8)) u_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_value(load_value), .mode(mode), .count(cnt_a), .gray(gray_a),
        .tc(tc_a), .done(done_a), .cur_up(cu_a), .wraps(wr_a)
    );

    mode_counter #(.WIDTH(4), .MAX_VAL(3), .WRAP_W(8)) u_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_value(load_value), .mode(mode), .count(cnt_b), .gray(gray_b),
        .tc(tc_b), .done(done_b), .cur_up(cu_b), .wraps(wr_b)
    );

    mode_counter #(.WIDTH(4), .MAX_VAL(9), .WRAP_W(2)) u_c (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_value(load_value), .mode(mode), .count(cnt_c), .gray(gray_c),
        .tc(tc_c), .done(done_c), .cur_up(cu_c), .wraps(wr_c)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state, one slot per instance.
    int m_max[3]  = '{9, 3, 9};
    int m_wmax[3] = '{255, 255, 3};
    int m_cnt[3];
    int m_wr[3];
    bit m_cu[3];
    bit m_done[3];
    bit m_tc[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_wr[i]   = 0;
            m_cu[i]   = 1'b1;
            m_done[i] = 1'b0;
            m_tc[i]   = 1'b0;
        end
    endtask

    // One clock edge of the rules: load beats counting; an attempt to step
    // outside 0..max is the terminal event, resolved per mode by wrapping,
    // stopping or reflecting.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int  mx;
            int  dir;
            int  nxt;
            bit  term;
            mx       = m_max[i];
            term     = 1'b0;
            m_tc[i]  = 1'b0;
            if (load) begin
                m_cnt[i]  = (int'(load_value) > mx) ? mx : int'(load_value);
                m_cu[i]   = up;
                m_done[i] = 1'b0;
            end else if (en && mode != 2'b11) begin
                if (mode == 2'b10) dir = m_cu[i] ? 1 : -1;
                else               dir = up ? 1 : -1;
                nxt = m_cnt[i] + dir;
                if (nxt < 0 || nxt > mx) begin
                    if (mode == 2'b00) begin
                        term     = 1'b1;
                        m_cnt[i] = (nxt + mx + 1) % (mx + 1);
                        m_cu[i]  = up;
                    end else if (mode == 2'b01) begin
                        if (!m_done[i]) begin
                            term      = 1'b1;
                            m_done[i] = 1'b1;
                            m_cu[i]   = up;
                        end
                    end else begin
                        term     = 1'b1;
                        m_cnt[i] = m_cnt[i] - dir;
                        m_cu[i]  = (dir < 0);
                    end
                end else if (!(mode == 2'b01 && m_done[i])) begin
                    m_cnt[i] = nxt;
                    if (mode != 2'b10) m_cu[i] = up;
                end
            end
            if (term) begin
                m_tc[i] = 1'b1;
                if (m_wr[i] < m_wmax[i]) m_wr[i]++;
            end
        end
    endtask

    task automatic check_dut(input string tag, input int i, input logic [31:0] c,
                             input logic [31:0] g, input logic [31:0] t, input logic [31:0] d,
                             input logic [31:0] cu, input logic [31:0] w);
        chk($sformatf("%s[%0d].count", tag, i), c, m_cnt[i]);
        chk($sformatf("%s[%0d].gray", tag, i), g, m_cnt[i] ^ (m_cnt[i] >> 1));
        chk($sformatf("%s[%0d].tc", tag, i), t, 32'(m_tc[i]));
        chk($sformatf("%s[%0d].done", tag, i), d, 32'(m_done[i]));
        chk($sformatf("%s[%0d].cur_up", tag, i), cu, 32'(m_cu[i]));
        chk($sformatf("%s[%0d].wraps", tag, i), w, m_wr[i]);
    endtask

    task automatic check_all(input string tag);
        check_dut(tag, 0, 32'(cnt_a), 32'(gray_a), 32'(tc_a), 32'(done_a), 32'(cu_a), 32'(wr_a));
        check_dut(tag, 1, 32'(cnt_b), 32'(gray_b), 32'(tc_b), 32'(done_b), 32'(cu_b), 32'(wr_b));
        check_dut(tag, 2, 32'(cnt_c), 32'(gray_c), 32'(tc_c), 32'(done_c), 32'(cu_c), 32'(wr_c));
    endtask

    // Inputs change 1 ns after an edge and are sampled at the next one.
    task automatic drive(input int l, input int lv, input int e, input int u, input int m);
        load       = 1'(l);
        load_value = 4'(lv);
        en         = 1'(e);
        up         = 1'(u);
        mode       = 2'(m);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    int pp_cnt[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int pp_tc[8]  = '{0, 0, 0, 1, 0, 0, 1, 0};
    int pp_cu[8]  = '{1, 1, 1, 0, 0, 0, 1, 1};
    int os_cnt[4] = '{8, 9, 9, 9};
    int os_dn[4]  = '{0, 0, 1, 1};
    int os_tc[4]  = '{0, 0, 1, 0};
    int wr_base;

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 1, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Async reset lands mid-cycle, 3 ns after an edge.
        drive(1, 5, 0, 1, 0);
        tick("load5");
        chk("async_pre.count", 32'(cnt_a), 5);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        chk("async_reset.count", 32'(cnt_a), 0);
        chk("async_reset.cur_up", 32'(cu_a), 1);
        #1;
        reset = 1'b0;
        drive(0, 0, 1, 1, 0);
        tick("resume");
        chk("resume.count", 32'(cnt_a), 1);

        // Free-run up from 0 over MAX_VAL=9.
        drive(1, 0, 0, 1, 0);
        tick("fr_ld0");
        drive(0, 0, 1, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            tick("fr_up");
            chk($sformatf("fr_up%0d.count", k), 32'(cnt_a), k % 10);
            chk($sformatf("fr_up%0d.tc", k), 32'(tc_a), (k == 10) ? 1 : 0);
            if (k == 9) chk("fr_up9.gray", 32'(gray_a), 32'b1101);
        end
        chk("fr_up.wraps", 32'(wr_a), 1);
        tick("fr_up_after");
        chk("fr_up_after.tc", 32'(tc_a), 0);

        // Free-run down from 0.
        drive(1, 0, 0, 0, 0);
        tick("fd_ld0");
        drive(0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick("fr_dn");
            chk($sformatf("fr_dn%0d.count", k), 32'(cnt_a), 9 - k);
            chk($sformatf("fr_dn%0d.tc", k), 32'(tc_a), (k == 0) ? 1 : 0);
        end

        // Five more wraps: the 2-bit counter must stick at 3.
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0, 0);
            tick("sat_ld");
            drive(0, 0, 1, 0, 0);
            tick("sat_wrap");
        end
        chk("sat.wraps_c", 32'(wr_c), 3);
        chk("sat.wraps_a", 32'(wr_a), 7);

        // One-shot up from 7.
        drive(1, 7, 0, 1, 1);
        tick("os_ld7");
        drive(0, 0, 1, 1, 1);
        for (int k = 0; k < 4; k++) begin
            tick("os");
            chk($sformatf("os%0d.count", k), 32'(cnt_a), os_cnt[k]);
            chk($sformatf("os%0d.done", k), 32'(done_a), os_dn[k]);
            chk($sformatf("os%0d.tc", k), 32'(tc_a), os_tc[k]);
        end
        drive(1, 2, 0, 1, 1);
        tick("os_ld2");
        chk("os_ld2.count", 32'(cnt_a), 2);
        chk("os_ld2.done", 32'(done_a), 0);
        drive(0, 0, 1, 1, 1);
        tick("os_resume");
        chk("os_resume.count", 32'(cnt_a), 3);

        // Ping-pong on MAX_VAL=3; up held low to show it is ignored.
        drive(1, 0, 0, 1, 2);
        tick("pp_ld0");
        wr_base = m_wr[1];
        drive(0, 0, 1, 0, 2);
        for (int k = 0; k < 8; k++) begin
            tick("pp");
            chk($sformatf("pp%0d.count", k), 32'(cnt_b), pp_cnt[k]);
            chk($sformatf("pp%0d.tc", k), 32'(tc_b), pp_tc[k]);
            chk($sformatf("pp%0d.cur_up", k), 32'(cu_b), pp_cu[k]);
        end
        chk("pp.wraps", 32'(wr_b), wr_base + 2);

        // Load corner cases.
        drive(1, 12, 0, 1, 0);
        tick("ld_sat");
        chk("ld_sat.count", 32'(cnt_a), 9);
        drive(1, 4, 1, 1, 0);
        tick("ld_en");
        chk("ld_en.count", 32'(cnt_a), 4);
        drive(0, 0, 1, 1, 3);
        tick("m11_a");
        tick("m11_b");
        chk("m11.count", 32'(cnt_a), 4);
        chk("m11.tc", 32'(tc_a), 0);

        // Randomised traffic with occasional mid-cycle resets.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 9) == 0) ? 1 : 0, int'($urandom_range(0, 15)),
                  ($urandom_range(0, 4) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)));
            tick("rnd");
            if ($urandom_range(0, 49) == 0) begin
                #2;
                reset = 1'b1;
                model_reset();
                #1;
                check_all("rnd_reset");
                reset = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mode_counter.md
Name: mode_counter

Overview:
Parametrised successor to the team's fixed-width free-running binary counter. It adds a configurable terminal value, count direction, synchronous load and enable, and three run modes: free-run wrap, one-shot and ping-pong. It also produces registered binary and Gray outputs, a terminal-count pulse and a saturating wrap counter. It is used as the general-purpose timer/sequencer counter in new designs.

Parameters:
WIDTH, 4, count width in bits
MAX_VAL, 2**WIDTH-1, terminal value; counting range is 0..MAX_VAL; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1
WRAP_W, 8, width of the wraps event counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  count enable
up  input  1  requested direction, 1 = up; used by modes 00/01 and on load
load  input  1  synchronous load strobe
load_value  input  WIDTH  value to load
mode  input  2  00 free-run, 01 one-shot, 10 ping-pong, 11 reserved (hold)
count  output  WIDTH  registered binary count
gray  output  WIDTH  registered Gray code of count
tc  output  1  registered one-cycle terminal-count pulse
done  output  1  one-shot finished flag (sticky)
cur_up  output  1  current effective direction
wraps  output  WRAP_W  saturating count of tc events

Behaviour:
- Reset (async, high): count=0, gray=0, tc=0, done=0, cur_up=1, wraps=0. Takes effect immediately, not at the next edge.
- All other state changes happen on the rising edge of clk.
- Priority per edge: load > en > hold.
- gray always equals count ^ (count >> 1). It updates on the same edge as count, with no extra latency.
- tc defaults to 0 every edge. It is 1 only for the cycle after an edge on which a terminal event occurred.
- load:
  - count <= min(load_value, MAX_VAL); load_value > MAX_VAL saturates to MAX_VAL.
  - cur_up <= up; done <= 0; tc <= 0; wraps unchanged.
- en=0 and load=0: all registers hold; tc <= 0.
- Mode 00 (free-run), direction = up, cur_up <= up:
  - up: count==MAX_VAL -> 0, terminal event; otherwise count+1.
  - down: count==0 -> MAX_VAL, terminal event; otherwise count-1.
  - Counts above MAX_VAL cannot occur.
- Mode 01 (one-shot), direction = up, cur_up <= up:
  - Steps as mode 00 until the edge on which it would cross the endpoint (up at MAX_VAL, down at 0).
  - On that edge: count holds, done <= 1, terminal event.
  - While done=1, en is ignored; only load or reset restarts.
- Mode 10 (ping-pong), direction = cur_up; up is ignored except on load:
  - cur_up=1 at MAX_VAL: count <= MAX_VAL-1, cur_up <= 0, terminal event.
  - cur_up=0 at 0: count <= 1, cur_up <= 1, terminal event.
  - Otherwise step by 1 in the current direction.
- Mode 11: treated as en=0 (hold, tc=0). load still works.
- Terminal event: tc <= 1; wraps <= wraps+1, saturating at all-ones with no rollover.
- done is cleared only by load or reset; changing mode does not clear it. done affects counting only in mode 01.
- A mode change takes effect at the next edge using the current count. No state is flushed.

Test Plan:
- Async reset: WIDTH=4, count=5. Assert reset 3 ns after an edge -> count=0, gray=0, cur_up=1, wraps=0 before the next edge. Deassert -> counting resumes from 0.
- Free-run up (MAX_VAL=9, mode 00, up=1, en=1, 10 edges from 0):
  - count 1..9 then 0; gray=1101 at count 9.
  - tc high for exactly the one cycle after the 9->0 edge; wraps=1.
- Free-run down from 0 (MAX_VAL=9): count 9, 8, 7; tc after the first edge only. Set WRAP_W=2 and force 5 wraps -> wraps stays 3.
- One-shot (MAX_VAL=9, mode 01, up=1):
  - Load 7, then 4 enabled edges -> 8, 9, 9, 9; done=1 after the third edge; tc exactly once.
  - Then load 2 -> count 2, done=0, counting resumes.
- Ping-pong (MAX_VAL=3, mode 10, from 0): 8 enabled edges -> 1, 2, 3, 2, 1, 0, 1, 2. tc after the 3->2 and 0->1 edges; cur_up toggles at each; wraps=2.
- Load corner cases (MAX_VAL=9):
  - load_value=12 -> count 9.
  - load=1 and en=1 on the same edge -> loaded value, no step.
  - mode 11 with en=1 -> count frozen, tc=0.
